// File: rtl/cordic_pkg.sv
// Shared Q16.16 constants for the CORDIC trig blocks: width, gain, angle
// limits and the per-stage arctangent table (degrees scaled by 2^16).
package cordic_pkg;

    localparam int W = 32;

    typedef logic signed [W-1:0] q16_t;

    localparam q16_t K      = 32'sh0000_9B74;
    localparam q16_t DEG90  = 32'sd5898240;
    localparam q16_t DEG180 = 32'sd11796480;

    function automatic q16_t atan_deg(input int idx);
        case (idx)
            0:       return 32'sd2949120;
            1:       return 32'sd1740992;
            2:       return 32'sd919872;
            3:       return 32'sd466944;
            4:       return 32'sd234368;
            5:       return 32'sd117312;
            6:       return 32'sd58688;
            7:       return 32'sd29312;
            8:       return 32'sd14656;
            9:       return 32'sd7360;
            10:      return 32'sd3648;
            11:      return 32'sd1856;
            12:      return 32'sd896;
            13:      return 32'sd448;
            14:      return 32'sd256;
            15:      return 32'sd128;
            default: return 32'sd0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_rot_stage.sv
// One registered rotation-mode CORDIC micro-rotation; rotates (x, y) towards
// the residual angle z by +/-ATAN_VAL and carries the fold flag along.
module cordic_rot_stage
    import cordic_pkg::*;
#(
    parameter int   SHIFT    = 0,
    parameter q16_t ATAN_VAL = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  q16_t x_in,
    input  q16_t y_in,
    input  q16_t z_in,
    input  logic neg_in,
    output q16_t x_out,
    output q16_t y_out,
    output q16_t z_out,
    output logic neg_out
);

    q16_t x_sh;
    q16_t y_sh;
    logic rot_pos;

    assign x_sh    = x_in >>> SHIFT;
    assign y_sh    = y_in >>> SHIFT;
    assign rot_pos = !z_in[W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_out   <= '0;
            y_out   <= '0;
            z_out   <= '0;
            neg_out <= 1'b0;
        end else if (rot_pos) begin
            x_out   <= x_in - y_sh;
            y_out   <= y_in + x_sh;
            z_out   <= z_in - ATAN_VAL;
            neg_out <= neg_in;
        end else begin
            x_out   <= x_in + y_sh;
            y_out   <= y_in - x_sh;
            z_out   <= z_in + ATAN_VAL;
            neg_out <= neg_in;
        end
    end

endmodule

// File: rtl/cordic_sin_cos.sv
// Pipelined rotation-mode CORDIC: Q16.16 degrees in, Q16.16 sine/cosine out,
// one sample per clock, fixed latency of PIPELINE+2 cycles.
module cordic_sin_cos
    import cordic_pkg::*;
#(
    parameter int PIPELINE = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] iAngle,
    input  logic         pre_valid,
    output logic [W-1:0] sin_o,
    output logic [W-1:0] cos_o,
    output logic         post_valid
);

    // pre_valid marks iAngle as a sample this cycle; post_valid marks the
    // matching result. There is no ready: the pipe never stalls, and data
    // registers advance every cycle whether or not the slot is valid.

    q16_t angle_s;
    q16_t clamp_c;
    q16_t fold_c;
    logic neg_c;

    q16_t x0_q, y0_q, z0_q;
    logic neg0_q;

    q16_t x_s   [0:PIPELINE];
    q16_t y_s   [0:PIPELINE];
    q16_t z_s   [0:PIPELINE];
    logic neg_s [0:PIPELINE];

    logic [PIPELINE:0] valid_chain;

    assign angle_s = q16_t'(iAngle);

    // Fold angles outside +/-90 into range by a half turn and negate later.
    always_comb begin
        clamp_c = angle_s;
        fold_c  = '0;
        neg_c   = 1'b0;
        if (angle_s > DEG180)
            clamp_c = DEG180;
        else if (angle_s < -DEG180)
            clamp_c = -DEG180;
        if (clamp_c > DEG90) begin
            fold_c = clamp_c - DEG180;
            neg_c  = 1'b1;
        end else if (clamp_c < -DEG90) begin
            fold_c = clamp_c + DEG180;
            neg_c  = 1'b1;
        end else begin
            fold_c = clamp_c;
            neg_c  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q   <= '0;
            y0_q   <= '0;
            z0_q   <= '0;
            neg0_q <= 1'b0;
        end else begin
            x0_q   <= K;
            y0_q   <= '0;
            z0_q   <= fold_c;
            neg0_q <= neg_c;
        end
    end

    assign x_s[0]   = x0_q;
    assign y_s[0]   = y0_q;
    assign z_s[0]   = z0_q;
    assign neg_s[0] = neg0_q;

    generate
        for (genvar i = 1; i <= PIPELINE; i++) begin : g_stage
            cordic_rot_stage #(
                .SHIFT    (i - 1),
                .ATAN_VAL (atan_deg(i - 1))
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .x_in    (x_s[i-1]),
                .y_in    (y_s[i-1]),
                .z_in    (z_s[i-1]),
                .neg_in  (neg_s[i-1]),
                .x_out   (x_s[i]),
                .y_out   (y_s[i]),
                .z_out   (z_s[i]),
                .neg_out (neg_s[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_chain <= '0;
        else
            valid_chain <= {valid_chain[PIPELINE-1:0], pre_valid};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_o      <= '0;
            cos_o      <= '0;
            post_valid <= 1'b0;
        end else begin
            post_valid <= valid_chain[PIPELINE];
            if (valid_chain[PIPELINE]) begin
                sin_o <= neg_s[PIPELINE] ? -y_s[PIPELINE] : y_s[PIPELINE];
                cos_o <= neg_s[PIPELINE] ? -x_s[PIPELINE] : x_s[PIPELINE];
            end else begin
                sin_o <= '0;
                cos_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_sin_cos.sv
// Bench for cordic_sin_cos: directed and random angles scored against a
// real-valued sine/cosine reference with exact-cycle latency checking.
module tb_cordic_sin_cos;

    localparam int LAT     = 18;
    localparam int TOL     = 66;
    localparam int DEG90   = 5898240;
    localparam int DEG180  = 11796480;
    localparam int STEP    = 737280;
    localparam real PI     = 3.14159265358979323846;

    logic        clk;
    logic        rst_n;
    logic [31:0] iAngle;
    logic        pre_valid;
    logic [31:0] sin_o;
    logic [31:0] cos_o;
    logic        post_valid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // {due cycle, expected sin, expected cos}
    logic [95:0] exp_q[$];

    cordic_sin_cos #(.PIPELINE(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iAngle     (iAngle),
        .pre_valid  (pre_valid),
        .sin_o      (sin_o),
        .cos_o      (cos_o),
        .post_valid (post_valid)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    // Reference: clamp to +/-180 degrees, then ideal trig scaled by 2^16.
    function automatic logic [95:0] ref_entry(input int ang, input int due);
        int   a;
        real  rad;
        int   s;
        int   c;
        a   = (ang > DEG180) ? DEG180 : ((ang < -DEG180) ? -DEG180 : ang);
        rad = (real'(a) / 65536.0) * PI / 180.0;
        s   = rnd($sin(rad) * 65536.0);
        c   = rnd($cos(rad) * 65536.0);
        return {32'(due), 32'(s), 32'(c)};
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp);
        int d;
        d = obs - exp;
        if (d < 0) d = -d;
        checks++;
        assert ((d <= TOL) === 1'b1)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (+/-%0d)", tag, obs, exp, TOL);
        end
    endtask

    // driver tasks
    task automatic send(input int ang);
        @(posedge clk);
        #1;
        pre_valid = 1'b1;
        iAngle    = 32'(ang);
        exp_q.push_back(ref_entry(ang, cyc + LAT));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            pre_valid = 1'b0;
            iAngle    = $urandom;
        end
    endtask

    // scoreboard: every cycle, either the due result or all-zero outputs
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0 && int'($signed(exp_q[0][95:64])) < cyc) begin
                check_eq("overdue_result", cyc, int'($signed(exp_q[0][95:64])));
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && int'($signed(exp_q[0][95:64])) == cyc) begin
                check_eq("post_valid_hi", int'(post_valid), 1);
                check_near("sin", int'($signed(sin_o)), int'($signed(exp_q[0][63:32])));
                check_near("cos", int'($signed(cos_o)), int'($signed(exp_q[0][31:0])));
                void'(exp_q.pop_front());
            end else begin
                check_eq("post_valid_lo", int'(post_valid), 0);
                check_eq("sin_idle", int'(sin_o), 0);
                check_eq("cos_idle", int'(cos_o), 0);
            end
        end
    end

    initial begin
        int gap;
        int wait_cycles;
        rst_n     = 1'b0;
        pre_valid = 1'b0;
        iAngle    = '0;
        #1;
        check_eq("reset_post_valid", int'(post_valid), 0);
        check_eq("reset_sin", int'(sin_o), 0);
        check_eq("reset_cos", int'(cos_o), 0);
        #22;
        rst_n = 1'b1;

        // single 0 degree pulse, then quiet so every other cycle is checked
        send(0);
        idle(25);

        // quadrant cases, including folded angles
        send(1966080);
        send(-2949120);
        idle(2);
        send(9830400);
        send(-7864320);
        idle(3);

        // boundaries: +/-90 not folded, +/-180, out of range clamps
        send(DEG90);
        send(-DEG90);
        send(DEG180);
        send(-DEG180);
        send(13107200);
        send(-13107200);
        idle(22);

        // 32 back-to-back steps of 11.25 degrees, a 3-cycle gap, 4 more
        for (int k = 0; k < 32; k++) send(-DEG180 + k * STEP);
        idle(3);
        for (int k = 32; k < 36; k++) send(-DEG180 + k * STEP);
        idle(20);

        // random angles including out-of-range, with random gaps
        for (int k = 0; k < 60; k++) begin
            send(int'($urandom_range(0, 2 * 13107200)) - 13107200);
            gap = int'($urandom_range(0, 3));
            if (gap == 3) idle(int'($urandom_range(1, 4)));
        end
        idle(LAT + 4);

        // reset with samples in flight: outputs must clear without a clock edge
        for (int k = 0; k < 28; k++) send(int'($urandom_range(0, 2 * DEG180)) - DEG180);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_post_valid", int'(post_valid), 0);
        check_eq("async_rst_sin", int'(sin_o), 0);
        check_eq("async_rst_cos", int'(cos_o), 0);
        exp_q.delete();
        pre_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(40);

        // one more sample to show the pipe restarts cleanly
        send(1966080);
        idle(2);
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 100) begin
            @(posedge clk);
            wait_cycles++;
        end
        check_eq("drain_queue_empty", exp_q.size(), 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
